mem_arbiter: RTL and testbench

Two-port arbiter that shares one variable-latency memory port between the instruction-fetch path and the load/store path of the RISC-V core. It sits between the core's fetch/data request ports and the unified memory. It serialises transactions, alternates grants under contention so neither port starves, and aborts with an error response if the memory does not acknowledge within a programmable number of cycles.

---
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port fetch/data arbiter sharing one variable-latency memory port
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset_l,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_ack,
    output logic            if_err,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_ack,
    output logic            d_err,
    output logic [DW-1:0]   d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic            m_ack,
    input  logic [DW-1:0]   m_rdata,
    output logic [1:0]      grant,
    output logic            busy
);

    localparam int          BW       = DW / 8;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic            last_d_q, last_d_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            m_req_q, m_req_d;
    logic            m_we_q, m_we_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_wdata_q, m_wdata_d;
    logic [BW-1:0]   m_be_q, m_be_d;
    logic [1:0]      grant_q, grant_d;
    logic            if_ack_q, if_ack_d, if_err_q, if_err_d;
    logic            d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        cnt_d      = cnt_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_be_d     = m_be_q;
        grant_d    = grant_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        if_err_d   = if_err_q;
        d_err_d    = d_err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                // Under contention the port that did not win last time goes first.
                if (if_req && (!d_req || last_d_q)) begin
                    m_we_d    = 1'b0;
                    m_addr_d  = if_addr;
                    m_wdata_d = '0;
                    m_be_d    = '1;
                    grant_d   = 2'b01;
                    last_d_d  = 1'b0;
                    cnt_d     = '0;
                    m_req_d   = 1'b1;
                    state_d   = S_WAIT;
                end else if (d_req) begin
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_be_d    = d_be;
                    grant_d   = 2'b10;
                    last_d_d  = 1'b1;
                    cnt_d     = '0;
                    m_req_d   = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // An ack in the last allowed cycle still counts as a completion.
                if (m_ack) begin
                    m_req_d = 1'b0;
                    state_d = S_RESP;
                    if (grant_q[0]) begin
                        if_ack_d = 1'b1;
                        if_err_d = 1'b0;
                        if (!m_we_q) if_rdata_d = m_rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        d_err_d = 1'b0;
                        if (!m_we_q) d_rdata_d = m_rdata;
                    end
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    m_req_d = 1'b0;
                    state_d = S_RESP;
                    if (grant_q[0]) begin
                        if_ack_d   = 1'b1;
                        if_err_d   = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= S_IDLE;
            last_d_q   <= 1'b1;
            cnt_q      <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_be_q     <= '0;
            grant_q    <= 2'b00;
            if_ack_q   <= 1'b0;
            if_err_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            cnt_q      <= cnt_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_be_q     <= m_be_d;
            grant_q    <= grant_d;
            if_ack_q   <= if_ack_d;
            if_err_q   <= if_err_d;
            d_ack_q    <= d_ack_d;
            d_err_q    <= d_err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign if_ack   = if_ack_q;
    assign if_err   = if_err_q;
    assign if_rdata = if_rdata_q;
    assign d_ack    = d_ack_q;
    assign d_err    = d_err_q;
    assign d_rdata  = d_rdata_q;
    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_be     = m_be_q;
    assign grant    = grant_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural memory and arbitration model
module tb_mem_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        ack_r = 1'b0, spur_ack = 1'b0;
    logic        m_ack;
    logic [31:0] m_rdata = '0;
    logic [1:0]  grant;
    logic        busy;

    assign m_ack = ack_r | spur_ack;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_l(reset_l),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ack(m_ack), .m_rdata(m_rdata), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory contents: written words first, else a fixed pattern per address.
    logic [31:0] phys_mem [logic [29:0]];
    logic [31:0] model_mem [logic [29:0]];

    function automatic logic [31:0] pattern(input logic [31:0] a);
        if (a == 32'h0) return 32'h00500093;
        if (a[31:28] == 4'h0) return {a[15:0] ^ 16'h5A5A, a[15:0] + 16'h1357};
        return 32'hC0DE0000 ^ a;
    endfunction

    function automatic logic [31:0] rd_phys(input logic [31:0] a);
        if (phys_mem.exists(a[31:2])) return phys_mem[a[31:2]];
        return pattern(a);
    endfunction

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (model_mem.exists(a[31:2])) return model_mem[a[31:2]];
        return pattern(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Memory responder: ack after lat wait cycles, lat from address bits or a manual setting.
    logic mem_auto = 1'b0;
    int   man_lat = 0;

    initial begin
        int  cyc, mcnt, cur_lat, exp_len;
        bit  active;
        active = 0; cyc = 0; mcnt = 0; cur_lat = 0;
        forever begin
            @(negedge clk);
            if (!reset_l) begin
                active = 0;
                ack_r  = 1'b0;
            end else if (m_req) begin
                if (!active) begin
                    active  = 1;
                    cyc     = 0;
                    mcnt    = 0;
                    cur_lat = mem_auto ? int'(m_addr[6:4]) : man_lat;
                end
                mcnt++;
                if (cyc == cur_lat) begin
                    ack_r = 1'b1;
                    if (m_we) phys_mem[m_addr[31:2]] = merge(rd_phys(m_addr), m_wdata, m_be);
                    else      m_rdata = rd_phys(m_addr);
                end else begin
                    ack_r   = 1'b0;
                    m_rdata = 32'hBAD0BAD0;
                end
                cyc++;
            end else begin
                if (active) begin
                    exp_len = (cur_lat + 1 < TO) ? cur_lat + 1 : TO;
                    chk("m_req_cycles", 32'(mcnt), 32'(exp_len));
                    active = 0;
                end
                ack_r = 1'b0;
            end
        end
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] drd;
    } exp_t;

    exp_t        if_q[$];
    exp_t        d_q[$];
    logic [31:0] exp_drd = '0;

    // Response monitor.
    initial begin
        logic pif, pd;
        exp_t e;
        pif = 1'b0; pd = 1'b0;
        forever begin
            @(negedge clk);
            if (if_ack) begin
                chk("if_ack_pulse", 32'(pif), 0);
                chk("ack_exclusive", 32'(d_ack), 0);
                chk("if_ack_grant", 32'(grant), 1);
                chk("if_ack_expected", 32'(if_q.size() != 0), 1);
                if (if_q.size() != 0) begin
                    e = if_q.pop_front();
                    chk("if_rdata", if_rdata, e.rdata);
                    chk("if_err", 32'(if_err), 32'(e.err));
                end
            end
            if (d_ack) begin
                chk("d_ack_pulse", 32'(pd), 0);
                chk("d_ack_grant", 32'(grant), 2);
                chk("d_ack_expected", 32'(d_q.size() != 0), 1);
                if (d_q.size() != 0) begin
                    e = d_q.pop_front();
                    chk("d_rdata", d_rdata, e.drd);
                    chk("d_err", 32'(d_err), 32'(e.err));
                end
            end
            pif = if_ack;
            pd  = d_ack;
        end
    end

    // Arbitration monitor: checks the winner and the latched m_* fields at each issue.
    logic [1:0] glog[$];

    initial begin
        logic [1:0]  gprev, last_g, expw;
        logic        r_if, r_d, r_we;
        logic [31:0] r_ia, r_da, r_dw;
        logic [3:0]  r_be;
        gprev = 2'b00; last_g = 2'b10;
        r_if = 0; r_d = 0; r_we = 0; r_ia = 0; r_da = 0; r_dw = 0; r_be = 0;
        forever begin
            @(negedge clk);
            if (!reset_l) begin
                last_g = 2'b10;
                gprev  = 2'b00;
            end else begin
                if (gprev == 2'b00 && grant != 2'b00) begin
                    expw = (r_if && (!r_d || last_g == 2'b10)) ? 2'b01 : (r_d ? 2'b10 : 2'b00);
                    chk("grant_winner", 32'(grant), 32'(expw));
                    chk("m_req_on_issue", 32'(m_req), 1);
                    glog.push_back(grant);
                    if (grant == 2'b01) begin
                        chk("f_m_addr", m_addr, r_ia);
                        chk("f_m_we", 32'(m_we), 0);
                        chk("f_m_wdata", m_wdata, 0);
                        chk("f_m_be", 32'(m_be), 32'hF);
                    end else begin
                        chk("d_m_addr", m_addr, r_da);
                        chk("d_m_we", 32'(m_we), 32'(r_we));
                        chk("d_m_wdata", m_wdata, r_dw);
                        chk("d_m_be", 32'(m_be), 32'(r_be));
                    end
                    last_g = grant;
                end
                gprev = grant;
            end
            r_if = if_req; r_d = d_req; r_ia = if_addr; r_da = d_addr;
            r_we = d_we; r_dw = d_wdata; r_be = d_be;
        end
    end

    task automatic fetch_issue(input logic [31:0] a);
        exp_t e;
        int   lat;
        lat     = mem_auto ? int'(a[6:4]) : man_lat;
        e.err   = (lat >= TO);
        e.rdata = e.err ? 32'd0 : rd_model(a);
        e.drd   = 32'd0;
        if_q.push_back(e);
        if_addr = a;
        if_req  = 1'b1;
    endtask

    task automatic fetch_wait();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!if_ack && n < 60);
        chk("if_ack_seen", 32'(if_ack), 1);
        if_req = 1'b0;
    endtask

    task automatic data_issue(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        int   lat;
        lat     = mem_auto ? int'(a[6:4]) : man_lat;
        e.err   = (lat >= TO);
        e.rdata = 32'd0;
        if (!we) begin
            e.drd = e.err ? 32'd0 : rd_model(a);
        end else begin
            if (!e.err) model_mem[a[31:2]] = merge(rd_model(a), wd, be);
            e.drd = e.err ? 32'd0 : exp_drd;
        end
        exp_drd = e.drd;
        d_q.push_back(e);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_be    = be;
        d_req   = 1'b1;
    endtask

    task automatic data_wait();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!d_ack && n < 60);
        chk("d_ack_seen", 32'(d_ack), 1);
        d_req = 1'b0;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_ctrl"}, 32'({m_req, m_we, grant, busy, if_ack, d_ack, if_err, d_err}), 0);
        chk({tag, "_m_addr"}, m_addr, 0);
        chk({tag, "_m_wdata"}, m_wdata, 0);
        chk({tag, "_m_be"}, 32'(m_be), 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
    endtask

    initial begin
        phys_mem[30'(32'h00000200 >> 2)]  = 32'h12345678;
        model_mem[30'(32'h00000200 >> 2)] = 32'h12345678;

        repeat (3) @(posedge clk);
        #1 rst_chk("reset");
        reset_l = 1'b1;

        // Single fetch, ack in the first m_req cycle.
        mem_auto = 1'b0; man_lat = 0;
        @(posedge clk); #1;
        fetch_issue(32'h0);
        @(posedge clk); #1;
        chk("f1_m_req_t1", 32'(m_req), 1);
        chk("f1_no_ack_t1", 32'(if_ack), 0);
        @(posedge clk); #1;
        chk("f1_ack_t2", 32'(if_ack), 1);
        chk("f1_m_req_t2", 32'(m_req), 0);
        if_req = 1'b0;
        @(posedge clk); #1;
        chk("f1_ack_gone", 32'(if_ack), 0);
        chk("f1_idle", 32'(busy), 0);

        // Load 0x12345678, then a store that must leave d_rdata alone.
        data_issue(1'b0, 32'h200, 32'h0, 4'h0);
        data_wait();
        @(posedge clk); #1;
        man_lat = 2;
        data_issue(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("st_m_req", 32'(m_req), 1);
            chk("st_m_we", 32'(m_we), 1);
            chk("st_m_addr", m_addr, 32'h100);
        end
        data_wait();
        @(posedge clk); #1;

        // Load that times out, then a late ack that must be ignored.
        man_lat = 7;
        data_issue(1'b0, 32'h10000300, 32'h0, 4'h0);
        data_wait();
        @(posedge clk); #1;
        @(posedge clk); #1;
        spur_ack = 1'b1;
        @(posedge clk); #1;
        spur_ack = 1'b0;
        chk("late_ack_busy", 32'(busy), 0);
        chk("late_ack_grant", 32'(grant), 0);
        chk("late_ack_m_req", 32'(m_req), 0);
        @(posedge clk); #1;
        chk("late_ack_no_d_ack", 32'(d_ack), 0);

        // Spurious ack in IDLE with no requests.
        spur_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("spur_busy", 32'(busy), 0);
            chk("spur_acks", 32'({if_ack, d_ack}), 0);
        end
        spur_ack = 1'b0;

        // Reset while a memory cycle is outstanding.
        d_we = 1'b0; d_addr = 32'h10000400; d_be = 4'h0; d_req = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_reset_m_req", 32'(m_req), 1);
        #1 reset_l = 1'b0;
        #1 rst_chk("mid_reset");
        d_req = 1'b0;
        exp_drd = '0;
        repeat (2) @(posedge clk);
        #1 reset_l = 1'b1;
        man_lat = 0;
        glog.delete();

        // Continuous contention: grants must alternate starting with fetch.
        fork
            for (int i = 0; i < 3; i++) begin
                fetch_issue(32'h00001000 + 32'(i) * 32'h10);
                fetch_wait();
            end
            for (int j = 0; j < 3; j++) begin
                data_issue(1'b0, 32'h10000800 + 32'(j) * 32'h4, 32'h0, 4'h0);
                data_wait();
            end
        join
        chk("contend_count", 32'(glog.size()), 6);
        for (int i = 0; i < glog.size() && i < 6; i++)
            chk("contend_grant", 32'(glog[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        @(posedge clk); #1;

        // Randomised traffic; latency comes from address bits, 4+ means timeout.
        mem_auto = 1'b1;
        fork
            for (int i = 0; i < 40; i++) begin
                int lat;
                lat = $urandom_range(0, 5);
                fetch_issue({4'h0, 21'($urandom), 3'(lat), 4'h0});
                fetch_wait();
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            for (int j = 0; j < 40; j++) begin
                int lat;
                logic we;
                lat = $urandom_range(0, 5);
                we  = 1'($urandom_range(0, 1));
                data_issue(we, {4'h1, 18'h0, 3'($urandom_range(0, 7)), 3'(lat), 4'h0},
                           $urandom, 4'($urandom_range(1, 15)));
                data_wait();
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        join

        repeat (10) @(posedge clk);
        #1;
        chk("if_q_drained", 32'(if_q.size()), 0);
        chk("d_q_drained", 32'(d_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
